regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (ad3/we3/wd3) between two writeback

---
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter for the register-file write port between
//               ALU (A) and load (B) writebacks. It also keeps a busy scoreboard
//               that decode uses to detect read-after-write hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_data,
    input  logic                     iss_valid,
    input  logic [ADDRESS_WIDTH-1:0] iss_addr,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] chk1,
    input  logic [ADDRESS_WIDTH-1:0] chk2,
    output logic                     hz1,
    output logic                     hz2,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic                     we3,
    output logic [DATA_WIDTH-1:0]    wd3
);

    localparam int NREGS = 1 << ADDRESS_WIDTH;

    // ptr_q = 0 gives A priority on contention, 1 gives B priority
    logic                     ptr_q, ptr_d;
    logic                     grant_a, grant_b, hs;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]    win_data;
    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
    logic [NREGS-1:0]         busy_q, busy_d;

    assign grant_a = rst_n & a_valid & (~b_valid | ~ptr_q);
    assign grant_b = rst_n & b_valid & (~a_valid | ptr_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign hs      = grant_a | grant_b;

    assign win_addr = grant_b ? b_addr : a_addr;
    assign win_data = grant_b ? b_data : a_data;

    always_comb begin
        ptr_d = ptr_q;
        if (a_valid && b_valid) begin
            ptr_d = ~ptr_q;
        end
    end

    // x0 writes still handshake, but they never reach the register file
    always_comb begin
        we3_d = hs && (win_addr != '0);
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (hs) begin
            ad3_d = win_addr;
            wd3_d = win_data;
        end
    end

    // A set wins over a retire-clear on the same register in the same cycle
    assign busy_d[0] = 1'b0;
    for (genvar i = 1; i < NREGS; i++) begin : g_busy
        assign busy_d[i] = ~flush &
            ((busy_q[i] & ~(we3_q && (ad3_q == ADDRESS_WIDTH'(i)))) |
             (iss_valid && (iss_addr == ADDRESS_WIDTH'(i))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            we3_q  <= 1'b0;
            ad3_q  <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we3_q  <= we3_d;
            ad3_q  <= ad3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign we3 = we3_q;
    assign ad3 = ad3_q;
    assign wd3 = wd3_q;
    assign hz1 = busy_q[chk1];
    assign hz2 = busy_q[chk2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed testbench for regfile_wb_arbiter. Expected values are
//               computed by hand for each step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, iss_addr, chk1, chk2, ad3;
    logic [31:0] a_data, b_data, wd3;
    logic        iss_valid, flush, hz1, hz2, we3;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .chk1(chk1), .chk2(chk2), .hz1(hz1), .hz2(hz2),
        .ad3(ad3), .we3(we3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd1; b_addr = 5'd2; a_data = 32'h1; b_data = 32'h2;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0; chk1 = 5'd5; chk2 = 5'd0;

        // 1 Reset
        step(); step();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_we3", we3, 0);
        chk("rst_hz1", hz1, 0);
        chk("rst_hz2", hz2, 0);
        chk("rst_ad3", ad3, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // 2 A alone
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF; #1;
        chk("a_alone_ready", a_ready, 1);
        chk("a_alone_b_ready", b_ready, 0);
        step(); a_valid = 1'b0;
        chk("a_alone_we3", we3, 1);
        chk("a_alone_ad3", ad3, 5);
        chk("a_alone_wd3", wd3, 32'hDEAD_BEEF);
        step();
        chk("a_alone_we3_off", we3, 0);
        chk("a_alone_ad3_hold", ad3, 5);

        // 3 Contention: A, B, A
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd11;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd22; #1;
        chk("cont1_a_ready", a_ready, 1);
        chk("cont1_b_ready", b_ready, 0);
        step();
        chk("cont1_ad3", ad3, 3);
        chk("cont1_wd3", wd3, 11);
        chk("cont2_a_ready", a_ready, 0);
        chk("cont2_b_ready", b_ready, 1);
        step();
        chk("cont2_ad3", ad3, 4);
        chk("cont2_wd3", wd3, 22);
        chk("cont2_we3", we3, 1);
        chk("cont3_a_ready", a_ready, 1);
        chk("cont3_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("cont3_ad3", ad3, 3);
        chk("cont3_wd3", wd3, 11);
        step();
        chk("cont_we3_off", we3, 0);

        // Pointer now at B: an uncontested A grant must not move it
        a_valid = 1'b1; a_addr = 5'd2; a_data = 32'd1; #1;
        chk("unc_a_ready", a_ready, 1);
        step();
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'd2; #1;
        chk("ptr_b_ready", b_ready, 1);
        chk("ptr_a_ready", a_ready, 0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // 4 Scoreboard
        chk1 = 5'd7; chk2 = 5'd7;
        iss_valid = 1'b1; iss_addr = 5'd7; #1;
        chk("sb_pre_hz1", hz1, 0);
        step(); iss_valid = 1'b0;
        chk("sb_set_hz1", hz1, 1);
        chk("sb_set_hz2", hz2, 1);
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd77;
        step(); b_valid = 1'b0;
        chk("sb_wr_we3", we3, 1);
        chk("sb_wr_hz1", hz1, 1);
        step();
        chk("sb_clr_hz1", hz1, 0);
        iss_valid = 1'b1; iss_addr = 5'd7;
        step(); iss_valid = 1'b0;
        chk("sb_reset_hz1", hz1, 1);
        b_valid = 1'b1;
        step(); b_valid = 1'b0;
        chk("sb_wr2_we3", we3, 1);
        iss_valid = 1'b1; iss_addr = 5'd7;
        step(); iss_valid = 1'b0;
        chk("sb_setwins_hz1", hz1, 1);
        iss_valid = 1'b1; iss_addr = 5'd0; chk2 = 5'd0;
        step(); iss_valid = 1'b0;
        chk("sb_x0_hz2", hz2, 0);

        // 5 x0 write and flush
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55; #1;
        chk("x0_a_ready", a_ready, 1);
        step(); a_valid = 1'b0;
        chk("x0_we3", we3, 0);
        iss_valid = 1'b1; iss_addr = 5'd9; chk2 = 5'd9;
        step(); iss_valid = 1'b0;
        chk("fl_pre_hz2", hz2, 1);
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'd66;
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd10;
        step();
        a_valid = 1'b0; flush = 1'b0; iss_valid = 1'b0;
        chk("fl_hz2_x9", hz2, 0);
        chk("fl_hz1_x7", hz1, 0);
        chk("fl_we3", we3, 1);
        chk("fl_ad3", ad3, 6);
        chk1 = 5'd10; #1;
        chk("fl_iss_ignored", hz1, 0);
        step();

        // 6 Asynchronous reset mid-operation
        iss_valid = 1'b1; iss_addr = 5'd12; chk1 = 5'd12;
        step(); iss_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd13; a_data = 32'hABCD;
        step(); a_valid = 1'b0;
        chk("mid_we3_pre", we3, 1);
        chk("mid_hz1_pre", hz1, 1);
        #2 rst_n = 1'b0; a_valid = 1'b1; #1;
        chk("mid_we3", we3, 0);
        chk("mid_hz1", hz1, 0);
        chk("mid_ad3", ad3, 0);
        chk("mid_wd3", wd3, 0);
        chk("mid_a_ready", a_ready, 0);
        step();
        rst_n = 1'b1; b_valid = 1'b1; #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
